ft_spi_slave: RTL and testbench

FT_SPI_SLAVE -- requirements
Module: ft_spi_slave

---
 rtl/ft_spi_pkg.sv | 14 +
 rtl/ft_spi_sync.sv | 36 +++
 rtl/ft_spi_slave.sv | 176 +++++++++++++++++
 tb/tb_ft_spi_slave.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ft_spi_pkg.sv
// Shared types and constants for the FT2232 SPI slave.
package ft_spi_pkg;

    localparam int               BYTE_W          = 8;
    localparam int               CNT_W           = $clog2(BYTE_W);
    localparam logic [BYTE_W-1:0] IDLE_TX_DEFAULT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        WAIT_IDLE
    } state_t;

endpackage

// File: rtl/ft_spi_sync.sv
// Multi-bit multi-stage synchronizer with rising/falling edge pulses on the
// synchronized value.
module ft_spi_sync #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] pipe [STAGES];
    logic [WIDTH-1:0] prev;

    // NOTE: every stage resets to the bus idle level; a partly reset pipeline
    // would release a phantom edge into the edge detector after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) pipe[i] <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
            prev <= pipe[STAGES-1];
        end
    end

    assign q    = pipe[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/ft_spi_slave.sv
// SPI mode-0 slave for the FT2232 link, oversampled on the system clock.
// Optional FT_SPI_BYTE_COUNT_EN adds o_byte_count (bytes in current frame).
module ft_spi_slave
    import ft_spi_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] IDLE_TX     = IDLE_TX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_FT_SCK,
    input  logic              i_FT_MOSI,
    input  logic              i_FT_CS,
    output logic              o_FT_MISO,
    output logic [BYTE_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    input  logic              i_rx_ready,
    input  logic [BYTE_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic              o_frame_start,
    output logic              o_frame_end,
    output logic              o_busy,
    output logic              o_overrun
`ifdef FT_SPI_BYTE_COUNT_EN
    ,
    output logic [15:0]       o_byte_count
`endif
);

    localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);

    logic [2:0] pin_s, pin_rise, pin_fall;
    logic       sck_rise, sck_fall, mosi_s, cs_s, cs_rise, cs_fall;

    ft_spi_sync #(
        .WIDTH     (3),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (3'b100)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({i_FT_CS, i_FT_MOSI, i_FT_SCK}),
        .q     (pin_s),
        .rise  (pin_rise),
        .fall  (pin_fall)
    );

    assign sck_rise = pin_rise[0];
    assign sck_fall = pin_fall[0];
    assign mosi_s   = pin_s[1];
    assign cs_s     = pin_s[2];
    assign cs_rise  = pin_rise[2];
    assign cs_fall  = pin_fall[2];

    logic unused_sync;
    assign unused_sync = ^{pin_s[0], pin_rise[1], pin_fall[1]};

    state_t               state_q, state_d;
    logic [SETTLE_W-1:0]  settle_cnt;
    logic                 settled;
    logic                 frame_start_w, frame_end_w;
    logic [CNT_W-1:0]     bit_cnt;
    logic [BYTE_W-2:0]    rx_shift;
    logic [BYTE_W-1:0]    tx_shift;
    logic                 load_pending;
    logic                 shifting, byte_done, load_req;

    // Until the synchronizer has filled, a low CS means a frame was already
    // running through reset and must be skipped.
    assign settled = (settle_cnt == SETTLE_W'(SYNC_STAGES + 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            settle_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (!settled) settle_cnt <= settle_cnt + SETTLE_W'(1);
        end
    end

    // NOTE: defaults first so every path assigns every output; no latches.
    always_comb begin
        state_d       = state_q;
        frame_start_w = 1'b0;
        frame_end_w   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!settled) begin
                    if (!cs_s) state_d = WAIT_IDLE;
                end else if (cs_fall) begin
                    state_d       = ACTIVE;
                    frame_start_w = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_end_w = 1'b1;
                end
            end
            WAIT_IDLE: if (cs_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    assign shifting  = (state_q == ACTIVE) && !frame_end_w;
    assign byte_done = shifting && sck_rise && (bit_cnt == CNT_W'(BYTE_W - 1));
    assign load_req  = frame_start_w || (shifting && sck_fall && load_pending);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt       <= '0;
            rx_shift      <= '0;
            tx_shift      <= IDLE_TX;
            load_pending  <= 1'b0;
            o_rx_data     <= '0;
            o_rx_valid    <= 1'b0;
            o_overrun     <= 1'b0;
            o_tx_ready    <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_end   <= 1'b0;
        end else begin
            o_frame_start <= frame_start_w;
            o_frame_end   <= frame_end_w;
            o_tx_ready    <= 1'b0;

            if (load_req) begin
                tx_shift   <= i_tx_valid ? i_tx_data : IDLE_TX;
                o_tx_ready <= i_tx_valid;
            end else if (shifting && sck_fall) begin
                tx_shift <= {tx_shift[BYTE_W-2:0], 1'b1};
            end

            if (frame_start_w || frame_end_w) begin
                bit_cnt      <= '0;
                load_pending <= 1'b0;
            end else if (shifting && sck_rise) begin
                rx_shift <= {rx_shift[BYTE_W-3:0], mosi_s};
                bit_cnt  <= bit_cnt + CNT_W'(1);
                if (byte_done) load_pending <= 1'b1;
            end else if (shifting && sck_fall) begin
                load_pending <= 1'b0;
            end

            // Completion wins over a same-cycle handshake of the older byte.
            if (o_rx_valid && i_rx_ready) o_rx_valid <= 1'b0;
            if (byte_done) begin
                o_rx_data  <= {rx_shift, mosi_s};
                o_rx_valid <= 1'b1;
                if (o_rx_valid && !i_rx_ready) o_overrun <= 1'b1;
            end
        end
    end

    assign o_FT_MISO = (state_q == ACTIVE) ? tx_shift[BYTE_W-1] : 1'b1;
    assign o_busy    = (state_q == ACTIVE);

`ifdef FT_SPI_BYTE_COUNT_EN
    logic [15:0] byte_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
        end else if (frame_start_w) begin
            byte_cnt <= '0;
        end else if (byte_done && byte_cnt != 16'hFFFF) begin
            byte_cnt <= byte_cnt + 16'(1);
        end
    end

    assign o_byte_count = byte_cnt;
`endif

endmodule

// File: tb/tb_ft_spi_slave.sv
// Testbench for ft_spi_slave: a mode-0 SPI master at clk/8 plus a frame-level
// reference model of the byte streams in both directions.
module tb_ft_spi_slave;
    import ft_spi_pkg::*;

    typedef logic [7:0] bq_t[$];

    localparam logic [7:0] IDLE_TX = 8'hFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0, mosi = 1'b0, cs = 1'b1;
    logic       miso;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, frame_start, frame_end, busy, overrun;
`ifdef FT_SPI_BYTE_COUNT_EN
    logic [15:0] byte_count;
`endif

    int checks = 0;
    int errors = 0;
    int n_fs = 0, n_fe = 0, n_txr = 0;
    bq_t txq, rxq;

    always #5 clk = ~clk;

    ft_spi_slave dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_FT_SCK      (sck),
        .i_FT_MOSI     (mosi),
        .i_FT_CS       (cs),
        .o_FT_MISO     (miso),
        .o_rx_data     (rx_data),
        .o_rx_valid    (rx_valid),
        .i_rx_ready    (rx_ready),
        .i_tx_data     (tx_data),
        .i_tx_valid    (tx_valid),
        .o_tx_ready    (tx_ready),
        .o_frame_start (frame_start),
        .o_frame_end   (frame_end),
        .o_busy        (busy),
        .o_overrun     (overrun)
`ifdef FT_SPI_BYTE_COUNT_EN
        ,
        .o_byte_count  (byte_count)
`endif
    );

    // Producer/consumer side, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (frame_start) n_fs++;
        if (frame_end) n_fe++;
        if (rx_valid && rx_ready) rxq.push_back(rx_data);
        if (tx_ready) begin
            n_txr++;
            if (txq.size() != 0) void'(txq.pop_front());
        end
        tx_valid = (txq.size() != 0);
        tx_data  = tx_valid ? txq[0] : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nb; i--) begin
            mosi = tx[i];
            tick(4);
            rx[i] = miso;
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
        end
    endtask

    task automatic spi_frame(input bq_t mo, output bq_t mi);
        logic [7:0] b;
        mi = {};
        cs = 1'b0;
        tick(4);
        check("busy_in_frame", busy, 1);
        foreach (mo[k]) begin
            spi_bits(mo[k], 8, b);
            mi.push_back(b);
        end
        tick(4);
        cs = 1'b1;
        tick(8);
    endtask

    // Byte k of a frame carries the k-th offered byte, or the idle pattern
    // once the offered bytes run out.
    function automatic logic [7:0] exp_miso(input bq_t offered, input int k);
        return (k < offered.size()) ? offered[k] : IDLE_TX;
    endfunction

    initial begin
        bq_t mo, mi, offered;
        int  fs0, fe0, txr0, n, len, exp_pulses;
        logic [7:0] junk;

        // Reset values while rst_n is held low.
        tick(3);
        check("rst_miso", miso, 1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_frame_end", frame_end, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        tick(10);

        // One byte A5 received, 3C offered for transmission.
        offered = {8'h3C};
        txq = offered;
        tick(3);
        fs0 = n_fs; fe0 = n_fe; txr0 = n_txr;
        mo = {8'hA5};
        spi_frame(mo, mi);
        check("a5_miso", mi[0], exp_miso(offered, 0));
        check("a5_tx_pulses", n_txr - txr0, 1);
        check("a5_frame_start", n_fs - fs0, 1);
        check("a5_frame_end", n_fe - fe0, 1);
        check("a5_rx_count", rxq.size(), 1);
        if (rxq.size() != 0) check("a5_rx_data", rxq[0], 8'hA5);
        check("a5_busy_after", busy, 0);
        check("a5_miso_idle", miso, 1);
        check("a5_no_overrun", overrun, 0);
`ifdef FT_SPI_BYTE_COUNT_EN
        check("a5_byte_count", byte_count, 1);
`endif
        txq.delete(); rxq.delete();
        tick(3);

        // Two bytes with nothing offered: idle pattern, no tx pulses.
        offered = {};
        txr0 = n_txr;
        mo = {8'($urandom), 8'($urandom)};
        spi_frame(mo, mi);
        check("idle_miso0", mi[0], exp_miso(offered, 0));
        check("idle_miso1", mi[1], exp_miso(offered, 1));
        check("idle_tx_pulses", n_txr - txr0, 0);
        check("idle_rx_count", rxq.size(), 2);
        if (rxq.size() == 2) begin
            check("idle_rx0", rxq[0], mo[0]);
            check("idle_rx1", rxq[1], mo[1]);
        end
        rxq.delete();

        // Randomized frames against the frame-level model.
        for (int it = 0; it < 6; it++) begin
            n   = $urandom_range(1, 3);
            len = $urandom_range(0, 4);
            mo = {}; offered = {};
            for (int k = 0; k < n; k++) mo.push_back(8'($urandom));
            for (int k = 0; k < len; k++) offered.push_back(8'($urandom));
            txq = offered;
            tick(3);
            fs0 = n_fs; fe0 = n_fe; txr0 = n_txr;
            spi_frame(mo, mi);
            exp_pulses = (len < n + 1) ? len : n + 1;
            for (int k = 0; k < n; k++) check("rnd_miso", mi[k], exp_miso(offered, k));
            check("rnd_tx_pulses", n_txr - txr0, exp_pulses);
            check("rnd_frames", {n_fs - fs0, n_fe - fe0}, {32'd1, 32'd1});
            check("rnd_rx_count", rxq.size(), n);
            if (rxq.size() == n) for (int k = 0; k < n; k++) check("rnd_rx", rxq[k], mo[k]);
            txq.delete(); rxq.delete();
            tick(3);
        end

        // Overrun: two bytes, consumer not ready.
        rx_ready = 1'b0;
        mo = {8'h01, 8'h02};
        spi_frame(mo, mi);
        check("ovr_valid", rx_valid, 1);
        check("ovr_data", rx_data, 8'h02);
        check("ovr_flag", overrun, 1);
`ifdef FT_SPI_BYTE_COUNT_EN
        check("ovr_byte_count", byte_count, 2);
`endif
        rx_ready = 1'b1;
        tick(2);
        check("ovr_consumed", rxq.size(), 1);
        if (rxq.size() != 0) check("ovr_consumed_data", rxq[0], 8'h02);
        check("ovr_valid_clr", rx_valid, 0);
        rxq.delete();

        // Frame aborted after five bits, then a full frame.
        fe0 = n_fe;
        cs = 1'b0;
        tick(4);
        spi_bits(8'($urandom), 5, junk);
        tick(4);
        cs = 1'b1;
        tick(8);
        check("part_no_rx", rxq.size(), 0);
        check("part_valid", rx_valid, 0);
        check("part_frame_end", n_fe - fe0, 1);
        mo = {8'h5A};
        spi_frame(mo, mi);
        check("part_next_count", rxq.size(), 1);
        if (rxq.size() != 0) check("part_next_data", rxq[0], 8'h5A);
        check("overrun_sticky", overrun, 1);
        rxq.delete();

        // Reset in the middle of a frame.
        cs = 1'b0;
        tick(4);
        spi_bits(8'hC3, 4, junk);
        rst_n = 1'b0;
        tick(2);
        check("mrst_miso", miso, 1);
        check("mrst_rx_data", rx_data, 8'h00);
        check("mrst_rx_valid", rx_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_overrun", overrun, 0);
        check("mrst_pulses", {frame_start, frame_end, tx_ready}, 0);
        rst_n = 1'b1;
        tick(2);
        fs0 = n_fs; fe0 = n_fe;
        spi_bits(8'h3C, 4, junk);
        spi_bits(8'h77, 8, junk);
        tick(4);
        cs = 1'b1;
        tick(8);
        check("mrst_ignored_rx", rxq.size(), 0);
        check("mrst_ignored_frames", {n_fs - fs0, n_fe - fe0}, 0);
        mo = {8'h96};
        spi_frame(mo, mi);
        check("mrst_next_count", rxq.size(), 1);
        if (rxq.size() != 0) check("mrst_next_data", rxq[0], 8'h96);
        check("mrst_next_miso", mi[0], IDLE_TX);
        check("mrst_next_frames", {n_fs - fs0, n_fe - fe0}, {32'd1, 32'd1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
